// File: rtl/div_pkg.sv
// Shared definitions for the sequential restoring divider: FSM state encoding
// and the default operand width with its matching step-counter width.
package div_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam int DIV_WIDTH = 4;
    localparam int CNT_W     = $clog2(DIV_WIDTH);

endpackage

// File: rtl/div_restore_step.sv
// One restoring-division row: trial-subtract the divisor from the shifted
// partial remainder and keep the difference only when it is non-negative.
module div_restore_step #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] rem_in,
    input  logic             bit_in,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] rem_out,
    output logic             q_bit
);

    logic [WIDTH:0] shifted;
    logic [WIDTH:0] trial;

    // rem_in < divisor keeps both operands below 2*divisor, so bit WIDTH is a clean sign
    assign shifted = {rem_in, bit_in};
    assign trial   = shifted - {1'b0, divisor};
    assign q_bit   = ~trial[WIDTH];
    assign rem_out = q_bit ? trial[WIDTH-1:0] : shifted[WIDTH-1:0];

endmodule

// File: rtl/seq_restoring_divider.sv
// Unsigned sequential restoring divider: one quotient bit per clock, MSB first,
// with a start/done handshake and a divide-by-zero flag.
module seq_restoring_divider
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_t           state, state_n;
    logic [WIDTH-1:0] dsr;
    logic [WIDTH-1:0] rem_acc;
    logic [WIDTH-1:0] q_acc;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] rem_next;
    logic             q_bit;

    div_restore_step #(.WIDTH(WIDTH)) u_step (
        .rem_in  (rem_acc),
        .bit_in  (q_acc[WIDTH-1]),
        .divisor (dsr),
        .rem_out (rem_next),
        .q_bit   (q_bit)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_n;
    end

    always_comb begin
        state_n = state;
        case (state)
            S_IDLE:  if (start) state_n = (divisor == '0) ? S_DONE : S_RUN;
            S_RUN:   if (cnt == LAST) state_n = S_DONE;
            S_DONE:  state_n = S_IDLE;
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dsr         <= '0;
            rem_acc     <= '0;
            q_acc       <= '0;
            cnt         <= '0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start && divisor != '0) begin
                        dsr         <= divisor;
                        rem_acc     <= '0;
                        q_acc       <= dividend;
                        cnt         <= '0;
                        div_by_zero <= 1'b0;
                    end else if (start) begin
                        quotient    <= '1;
                        remainder   <= dividend;
                        div_by_zero <= 1'b1;
                    end
                end
                S_RUN: begin
                    rem_acc <= rem_next;
                    q_acc   <= {q_acc[WIDTH-2:0], q_bit};
                    // Counter stops at the final step instead of wrapping
                    if (cnt == LAST) begin
                        quotient  <= {q_acc[WIDTH-2:0], q_bit};
                        remainder <= rem_next;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy = (state == S_RUN);
    assign done = (state == S_DONE);

endmodule

// File: tb/tb_seq_restoring_divider.sv
// Self-checking bench for seq_restoring_divider (WIDTH=4): directed cases,
// handshake/reset corner cases, an exhaustive sweep and random pairs.
module tb_seq_restoring_divider;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [W-1:0] dividend = '0;
    logic [W-1:0] divisor = '0;
    logic         busy, done, div_by_zero;
    logic [W-1:0] quotient, remainder;

    int checks = 0;
    int passed = 0;
    int fails  = 0;
    int lat, bcnt, ndone;
    bit tmo;
    logic [W-1:0] cap_q, cap_r;

    always #5 clk = ~clk;

    seq_restoring_divider #(.WIDTH(W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Start one divide from IDLE and wait (bounded) for done; operands are
    // scrambled while the divide runs since only the accept edge may sample them.
    task automatic do_div(input logic [W-1:0] a, input logic [W-1:0] b);
        @(negedge clk);
        dividend = a;
        divisor  = b;
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        lat   = 0;
        bcnt  = 0;
        while (done !== 1'b1 && lat < 20) begin
            if (busy === 1'b1) bcnt++;
            dividend = W'($urandom);
            divisor  = W'($urandom);
            @(negedge clk);
            lat++;
        end
        tmo = (done !== 1'b1);
    endtask

    // Reference: plain integer division, with the all-ones/dividend rule for b==0.
    task automatic check_result(input string tag, input logic [W-1:0] a, input logic [W-1:0] b);
        int eq, er, ez;
        if (b == 0) begin
            eq = (1 << W) - 1;
            er = a;
            ez = 1;
        end else begin
            eq = a / b;
            er = a % b;
            ez = 0;
        end
        check({tag, " timeout"}, 32'(tmo), 32'd0);
        check({tag, " quotient"}, 32'(quotient), 32'(eq));
        check({tag, " remainder"}, 32'(remainder), 32'(er));
        check({tag, " div_by_zero"}, 32'(div_by_zero), 32'(ez));
    endtask

    initial begin
        // Reset state
        #1;
        check("reset busy", 32'(busy), 32'd0);
        check("reset done", 32'(done), 32'd0);
        check("reset quotient", 32'(quotient), 32'd0);
        check("reset remainder", 32'(remainder), 32'd0);
        check("reset div_by_zero", 32'(div_by_zero), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // 13/3 with latency and busy length
        do_div(4'd13, 4'd3);
        check_result("13/3", 4'd13, 4'd3);
        check("13/3 latency", 32'(lat), 32'd4);
        check("13/3 busy cycles", 32'(bcnt), 32'd4);
        @(negedge clk);
        check("13/3 done one cycle", 32'(done), 32'd0);
        check("13/3 quotient holds", 32'(quotient), 32'd4);

        do_div(4'd5, 4'd7);   check_result("5/7", 4'd5, 4'd7);
        do_div(4'd15, 4'd1);  check_result("15/1", 4'd15, 4'd1);
        do_div(4'd15, 4'd15); check_result("15/15", 4'd15, 4'd15);

        // Divide by zero, then a normal divide clears the flag
        do_div(4'd9, 4'd0);
        check_result("9/0", 4'd9, 4'd0);
        check("9/0 latency", 32'(lat), 32'd0);
        check("9/0 busy cycles", 32'(bcnt), 32'd0);
        do_div(4'd6, 4'd2);   check_result("6/2", 4'd6, 4'd2);

        // start during RUN is ignored
        @(negedge clk);
        @(negedge clk);
        dividend = 4'd13; divisor = 4'd3; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        dividend = 4'd8; divisor = 4'd2; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        ndone = 0;
        cap_q = '0;
        cap_r = '0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                if (ndone == 0) begin
                    cap_q = quotient;
                    cap_r = remainder;
                end
                ndone++;
            end
        end
        check("ignored start done pulses", 32'(ndone), 32'd1);
        check("ignored start quotient", 32'(cap_q), 32'd4);
        check("ignored start remainder", 32'(cap_r), 32'd1);

        // Asynchronous reset mid-RUN aborts without a done pulse
        @(negedge clk);
        dividend = 4'd13; divisor = 4'd3; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("midreset busy", 32'(busy), 32'd0);
        check("midreset done", 32'(done), 32'd0);
        check("midreset quotient", 32'(quotient), 32'd0);
        check("midreset remainder", 32'(remainder), 32'd0);
        check("midreset div_by_zero", 32'(div_by_zero), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        ndone = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (done === 1'b1) ndone++;
        end
        check("midreset no done", 32'(ndone), 32'd0);
        do_div(4'd10, 4'd3);  check_result("10/3", 4'd10, 4'd3);

        // Exhaustive sweep with the divide identity
        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                do_div(W'(a), W'(b));
                check_result("sweep", W'(a), W'(b));
                if (b != 0) begin
                    check("sweep identity", 32'(int'(quotient) * b + int'(remainder)), 32'(a));
                    check("sweep rem<div", 32'(int'(remainder) < b), 32'd1);
                end
            end
        end

        // Random pairs with random idle gaps
        for (int n = 0; n < 40; n++) begin
            logic [W-1:0] ra, rb;
            ra = W'($urandom);
            rb = W'($urandom);
            repeat ($urandom_range(0, 3)) @(negedge clk);
            do_div(ra, rb);
            check_result("random", ra, rb);
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
